// File: rtl/adc_sreg_slave.sv
// adc_sreg_slave
//   Receiving end of the ADC 3-wire configuration link. Each 16-slot frame
//   (R/W, address, dummy bits, data; MSB first) is shifted in while ad_sload
//   is low and is committed into a 12 x 9-bit register file once ad_sload
//   returns high. Read frames return the addressed register on sdo during
//   the data slots.
//
// Ports
//   adc_clk      in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   ad_sload     in   frame enable, active low
//   ad_sdata     in   serial data from the master, MSB first
//   sdo          out  serial read data (0 whenever sdo_oe is low)
//   sdo_oe       out  high while sdo is driven
//   wr_valid     out  one-cycle pulse on a committed write
//   wr_addr      out  address of the last committed write (held)
//   wr_data      out  data of the last committed write (held)
//   rd_done      out  one-cycle pulse when a read frame completes
//   frame_err    out  one-cycle pulse on a malformed frame
//   all_written  out  sticky, every implemented address written
//   reg_rd_addr  in   side read-port address
//   reg_rd_data  out  side read-port data, 1-cycle latency
//
// FSM states
//   state     | meaning
//   S_IDLE    | waiting for ad_sload low; captures slot 0 (R/W)
//   S_SHIFT   | shifting slots 1..15; commit or abort on ad_sload high
//   S_OVERRUN | frame longer than 16 slots; wait for release, then error
module adc_sreg_slave #(
    parameter int NUM_REGS   = 12,
    parameter int ADDR_W     = 4,
    parameter int DUMMY_BITS = 2,
    parameter int DATA_W     = 9
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              ad_sload,
    input  logic              ad_sdata,
    output logic              sdo,
    output logic              sdo_oe,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_done,
    output logic              frame_err,
    output logic              all_written,
    input  logic [ADDR_W-1:0] reg_rd_addr,
    output logic [DATA_W-1:0] reg_rd_data
);

    localparam int FL    = 1 + ADDR_W + DUMMY_BITS + DATA_W;
    localparam int SR_W  = FL - 1;
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [4:0]        LP_FL        = 5'(FL);
    localparam logic [4:0]        LP_ADDR_LAST = 5'(ADDR_W);
    localparam logic [4:0]        LP_SDO_FIRST = 5'(ADDR_W + DUMMY_BITS);
    localparam logic [4:0]        LP_SDO_LAST  = 5'(FL - 2);
    localparam logic [ADDR_W:0]   LP_NREGS     = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_OVERRUN
    } state_t;

    state_t              r_state;
    logic [4:0]          r_cnt;
    logic                r_rw;
    logic [SR_W-1:0]     r_sr;
    logic [DATA_W-1:0]   r_rd_lat;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_mask;

    logic                r_sdo;
    logic                r_sdo_oe;
    logic                r_wr_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_rd_done;
    logic                r_frame_err;
    logic                r_all_written;
    logic [DATA_W-1:0]   r_reg_rd_data;

    // Address is complete while the last address slot is on the wire, so the
    // read latch uses the live input as the address LSB.
    logic [ADDR_W-1:0]   w_addr_now;
    logic                w_addr_now_ok;
    logic [ADDR_W-1:0]   w_cm_addr;
    logic [DATA_W-1:0]   w_cm_data;
    logic                w_cm_addr_ok;
    logic                w_side_ok;
    logic [IDX_W-1:0]    w_sdo_idx;
    logic [NUM_REGS-1:0] w_mask_set;

    assign w_addr_now    = {r_sr[ADDR_W-2:0], ad_sdata};
    assign w_addr_now_ok = ({1'b0, w_addr_now} < LP_NREGS);
    assign w_cm_addr     = r_sr[SR_W-1 -: ADDR_W];
    assign w_cm_data     = r_sr[DATA_W-1:0];
    assign w_cm_addr_ok  = ({1'b0, w_cm_addr} < LP_NREGS);
    assign w_side_ok     = ({1'b0, reg_rd_addr} < LP_NREGS);
    // Bit presented on sdo is the one the master samples on the next slot.
    assign w_sdo_idx     = IDX_W'(LP_SDO_LAST - r_cnt);

    always_comb begin
        w_mask_set = r_mask;
        if (w_cm_addr_ok) begin
            w_mask_set[w_cm_addr] = 1'b1;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rw          <= 1'b0;
            r_sr          <= '0;
            r_rd_lat      <= '0;
            r_mask        <= '0;
            r_sdo         <= 1'b0;
            r_sdo_oe      <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_rd_done     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_all_written <= 1'b0;
            r_reg_rd_data <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_valid  <= 1'b0;
            r_rd_done   <= 1'b0;
            r_frame_err <= 1'b0;

            // Non-blocking read gives read-before-write against a same-cycle commit.
            r_reg_rd_data <= w_side_ok ? r_regs[reg_rd_addr] : '0;

            case (r_state)
                S_IDLE: begin
                    r_sdo    <= 1'b0;
                    r_sdo_oe <= 1'b0;
                    if (!ad_sload) begin
                        r_rw    <= ad_sdata;
                        r_cnt   <= 5'd1;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (!ad_sload) begin
                        if (r_cnt < LP_FL) begin
                            r_sr  <= {r_sr[SR_W-2:0], ad_sdata};
                            r_cnt <= r_cnt + 5'd1;
                            if (r_cnt == LP_ADDR_LAST) begin
                                r_rd_lat <= w_addr_now_ok ? r_regs[w_addr_now] : '0;
                            end
                            if (!r_rw && r_cnt >= LP_SDO_FIRST && r_cnt <= LP_SDO_LAST) begin
                                r_sdo_oe <= 1'b1;
                                r_sdo    <= r_rd_lat[w_sdo_idx];
                            end else begin
                                r_sdo_oe <= 1'b0;
                                r_sdo    <= 1'b0;
                            end
                        end else begin
                            // cnt stays at FL while overrun
                            r_state <= S_OVERRUN;
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                        r_sdo    <= 1'b0;
                        r_sdo_oe <= 1'b0;
                        if (r_cnt == LP_FL) begin
                            if (r_rw) begin
                                if (w_cm_addr_ok) begin
                                    r_regs[w_cm_addr] <= w_cm_data;
                                    r_mask            <= w_mask_set;
                                    r_all_written     <= &w_mask_set;
                                    r_wr_valid        <= 1'b1;
                                    r_wr_addr         <= w_cm_addr;
                                    r_wr_data         <= w_cm_data;
                                end else begin
                                    r_frame_err <= 1'b1;
                                end
                            end else begin
                                r_rd_done <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end

                S_OVERRUN: begin
                    r_sdo    <= 1'b0;
                    r_sdo_oe <= 1'b0;
                    if (ad_sload) begin
                        r_frame_err <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign sdo         = r_sdo;
    assign sdo_oe      = r_sdo_oe;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign rd_done     = r_rd_done;
    assign frame_err   = r_frame_err;
    assign all_written = r_all_written;
    assign reg_rd_data = r_reg_rd_data;

endmodule

// File: tb/tb_adc_sreg_slave.sv
// tb_adc_sreg_slave
//   Drives SLOAD/SDATA frames (directed and random) into adc_sreg_slave and
//   compares every output against a frame-level model of the register file.
//   Inputs change on the falling edge; outputs are observed on the falling
//   edge before new inputs are applied.
module tb_adc_sreg_slave;

    localparam int NR = 12;

    logic       adc_clk = 1'b0;
    logic       reset = 1'b1;
    logic       ad_sload = 1'b1;
    logic       ad_sdata = 1'b0;
    logic [3:0] reg_rd_addr = '0;
    logic       sdo, sdo_oe, wr_valid, rd_done, frame_err, all_written;
    logic [3:0] wr_addr;
    logic [8:0] wr_data, reg_rd_data;

    adc_sreg_slave dut (
        .adc_clk     (adc_clk),
        .reset       (reset),
        .ad_sload    (ad_sload),
        .ad_sdata    (ad_sdata),
        .sdo         (sdo),
        .sdo_oe      (sdo_oe),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_done     (rd_done),
        .frame_err   (frame_err),
        .all_written (all_written),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data)
    );

    always #5 adc_clk = ~adc_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] m_regs [NR];
    bit         m_written [NR];
    logic [3:0] m_wr_addr;
    logic [8:0] m_wr_data;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_all();
        bit r = 1'b1;
        for (int i = 0; i < NR; i++) r &= m_written[i];
        return r;
    endfunction

    function automatic logic [8:0] m_peek(input logic [3:0] a);
        return (int'(a) < NR) ? m_regs[a] : 9'd0;
    endfunction

    function automatic logic [15:0] mk(input bit rw, input logic [3:0] a,
                                       input logic [1:0] d, input logic [8:0] v);
        return {rw, a, d, v};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i]    = '0;
            m_written[i] = 1'b0;
        end
        m_wr_addr = '0;
        m_wr_data = '0;
    endtask

    // Called and returns at a falling edge.
    task automatic do_reset();
        reset    = 1'b1;
        ad_sload = 1'b1;
        @(negedge adc_clk);
        reset = 1'b0;
        model_reset();
        chk_eq("rst_wr_valid", wr_valid, 0);
        chk_eq("rst_rd_done", rd_done, 0);
        chk_eq("rst_frame_err", frame_err, 0);
        chk_eq("rst_sdo_oe", sdo_oe, 0);
        chk_eq("rst_sdo", sdo, 0);
        chk_eq("rst_all_written", all_written, 0);
        chk_eq("rst_wr_addr", wr_addr, 0);
        chk_eq("rst_wr_data", wr_data, 0);
        chk_eq("rst_reg_rd_data", reg_rd_data, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ad_sload = 1'b1;
            @(negedge adc_clk);
            chk_eq("idle_wr_valid", wr_valid, 0);
            chk_eq("idle_rd_done", rd_done, 0);
            chk_eq("idle_frame_err", frame_err, 0);
            chk_eq("idle_sdo_oe", sdo_oe, 0);
        end
    endtask

    task automatic side_sweep();
        for (int a = 0; a < 16; a++) begin
            reg_rd_addr = 4'(a);
            ad_sload    = 1'b1;
            @(negedge adc_clk);
            chk_eq("side_rd", reg_rd_data, m_peek(4'(a)));
        end
    endtask

    // Sends nbits slots of word (extra slots beyond 16 carry random data),
    // then releases ad_sload and checks the commit cycle.
    task automatic send_frame(input logic [15:0] word, input int nbits);
        bit         rw;
        logic [3:0] addr;
        logic [8:0] data, lat, old_side;
        bit         exp_oe, e_wr, e_rd, e_err;
        int         k;
        rw   = word[15];
        addr = word[14:11];
        data = word[8:0];
        lat  = m_peek(addr);
        for (int i = 0; i < nbits; i++) begin
            ad_sload = 1'b0;
            if (i < 16) ad_sdata = word[15-i];
            else        ad_sdata = 1'($urandom_range(0, 1));
            @(negedge adc_clk);
            k = i + 1;
            exp_oe = !rw && k >= 7 && k <= 15;
            chk_eq("sdo_oe", sdo_oe, exp_oe);
            chk_eq("sdo", sdo, exp_oe ? lat[15-k] : 1'b0);
            chk_eq("mid_wr_valid", wr_valid, 0);
            chk_eq("mid_rd_done", rd_done, 0);
            chk_eq("mid_frame_err", frame_err, 0);
        end
        ad_sload    = 1'b1;
        old_side    = m_peek(addr);
        reg_rd_addr = addr;
        @(negedge adc_clk);
        e_wr  = 1'b0;
        e_rd  = 1'b0;
        e_err = 1'b0;
        if (nbits == 16) begin
            if (rw) begin
                if (int'(addr) < NR) begin
                    e_wr              = 1'b1;
                    m_regs[addr]      = data;
                    m_written[addr]   = 1'b1;
                    m_wr_addr         = addr;
                    m_wr_data         = data;
                end else begin
                    e_err = 1'b1;
                end
            end else begin
                e_rd = 1'b1;
            end
        end else begin
            e_err = 1'b1;
        end
        chk_eq("wr_valid", wr_valid, e_wr);
        chk_eq("rd_done", rd_done, e_rd);
        chk_eq("frame_err", frame_err, e_err);
        chk_eq("wr_addr", wr_addr, m_wr_addr);
        chk_eq("wr_data", wr_data, m_wr_data);
        chk_eq("all_written", all_written, m_all());
        chk_eq("end_sdo_oe", sdo_oe, 0);
        chk_eq("end_sdo", sdo, 0);
        chk_eq("rbw_side_rd", reg_rd_data, old_side);
    endtask

    initial begin
        int nb, r;
        @(negedge adc_clk);
        do_reset();
        idle(2);

        send_frame(mk(1'b1, 4'd2, 2'b00, 9'h1A5), 16);
        idle(1);
        reg_rd_addr = 4'd2;
        @(negedge adc_clk);
        chk_eq("side_rd_0x1a5", reg_rd_data, 9'h1A5);

        send_frame(mk(1'b0, 4'd2, 2'b00, 9'h000), 16);
        idle(2);

        send_frame(mk(1'b1, 4'd2, 2'b00, 9'h0F0), 10);
        idle(2);
        send_frame(mk(1'b1, 4'd13, 2'b00, 9'h055), 16);
        idle(2);
        send_frame(mk(1'b1, 4'd3, 2'b00, 9'h077), 20);
        idle(2);
        send_frame(mk(1'b0, 4'd14, 2'b11, 9'h1FF), 16);
        idle(2);
        side_sweep();

        for (int a = 0; a < NR; a++) begin
            send_frame(mk(1'b1, 4'(a), 2'b00, 9'(a + 'h100)), 16);
            idle(4);
        end
        side_sweep();

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 7)      nb = int'($urandom_range(1, 15));
            else if (r == 8) nb = int'($urandom_range(17, 22));
            else             nb = 16;
            send_frame(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          2'($urandom), 9'($urandom)), nb);
            idle(int'($urandom_range(0, 3)));
        end
        side_sweep();

        for (int i = 0; i < 8; i++) begin
            ad_sload = 1'b0;
            ad_sdata = mk(1'b1, 4'd7, 2'b00, 9'h1C3) >> (15 - i);
            @(negedge adc_clk);
        end
        do_reset();
        idle(3);
        send_frame(mk(1'b1, 4'd5, 2'b00, 9'h0FF), 16);
        idle(2);
        side_sweep();
        chk_eq("post_rst_all_written", all_written, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sreg_slave.md
Name: adc_sreg_slave

Overview:
- Serial-port responder for the ADC 3-wire configuration link: the receiving end of the SLOAD/SDATA frames our ADC init writer produces.
- Decodes each 16-bit frame into a 12-entry × 9-bit register file and answers read frames on a separate data-out line.
- Used as the ADC-side model in system benches and as the register mirror in the loopback/self-test build.

Parameters:
- NUM_REGS, 12, number of implemented registers; addresses 0..NUM_REGS-1 are valid.
- ADDR_W, 4, address field width.
- DUMMY_BITS, 2, don't-care bits between address and data.
- DATA_W, 9, data field width; frame length FL = 1 + ADDR_W + DUMMY_BITS + DATA_W = 16.

Ports:
- adc_clk, in, 1, sole clock; all logic on the rising edge.
- reset, in, 1, synchronous active-high reset.
- ad_sload, in, 1, frame enable, active low.
- ad_sdata, in, 1, serial data from the master, MSB first.
- sdo, out, 1, serial read data.
- sdo_oe, out, 1, high while the slave drives sdo.
- wr_valid, out, 1, one-cycle pulse when a write commits.
- wr_addr, out, ADDR_W, address of the committed write.
- wr_data, out, DATA_W, data of the committed write.
- rd_done, out, 1, one-cycle pulse when a read frame completes.
- frame_err, out, 1, one-cycle pulse when a frame is malformed.
- all_written, out, 1, sticky; set once every address 0..NUM_REGS-1 has been written.
- reg_rd_addr, in, ADDR_W, side read-port address.
- reg_rd_data, out, DATA_W, side read-port data, registered, 1-cycle latency.

Behaviour:
- Reset: applies only when reset is high at an adc_clk rising edge.
  - All outputs go to 0.
  - Register file clears to 0; written-mask clears.
  - FSM goes to IDLE and the bit counter to 0.
  - A frame in progress is abandoned with no pulses.
- Frame format, in slot order:
  - Slot 0: R/W (1 = write, 0 = read).
  - Slots 1..4: address, MSB first.
  - Slots 5..6: dummy bits, ignored.
  - Slots 7..15: data, MSB first.
- Sampling: ad_sload and ad_sdata are sampled on the rising edge; the master changes them on the falling edge.
- FSM states:
  - IDLE: when ad_sload is sampled 0, capture slot 0, set cnt = 1, go to SHIFT.
  - SHIFT:
    - ad_sload = 0 and cnt < FL: shift in ad_sdata, cnt++.
    - ad_sload = 0 and cnt = FL: go to OVERRUN.
    - ad_sload = 1 and cnt = FL: commit, go to IDLE.
    - ad_sload = 1 and cnt < FL: pulse frame_err, discard, go to IDLE.
  - OVERRUN: wait for ad_sload = 1, then pulse frame_err and go to IDLE; nothing commits.
- Commit (all pulses are registered, asserted in the cycle after ad_sload is sampled high):
  - Write, addr < NUM_REGS: update the register, pulse wr_valid with wr_addr/wr_data, set the mask bit.
  - Write, addr ≥ NUM_REGS: pulse frame_err; no write.
  - Read, any addr: pulse rd_done.
- wr_addr/wr_data hold their last value between pulses.
- Read data path:
  - At the edge that samples slot 4 (address complete), latch the read data. It is regfile[addr] if addr < NUM_REGS, else 0.
  - At the edge sampling slot k-1, for k = 7..15: drive sdo = latched bit (15-k) and sdo_oe = 1.
  - Drop sdo_oe to 0 at the edge sampling slot 15, or at any frame abort.
  - sdo = 0 whenever sdo_oe = 0.
  - Write frames never assert sdo_oe.
- all_written = AND of the mask, sticky until reset; it rises in the same cycle as the wr_valid that completes the mask.
- Side read port: reg_rd_data = regfile[reg_rd_addr] one cycle later.
  - Same-cycle commit to the same address returns the old value (read-before-write).
  - Address ≥ NUM_REGS returns 0.
- Back-to-back frames: a single sampled ad_sload = 1 between frames is sufficient; the commit and the next frame's slot 0 may occur in adjacent cycles.
- Data arithmetic: none beyond the counter; cnt is 5 bits and saturates at FL in OVERRUN.

Test Plan:
- Write frame, addr 2, data 0x1A5 (bits 1,0010,00,110100101) → wr_valid one cycle after ad_sload rises; wr_addr = 2, wr_data = 0x1A5; reg_rd_addr = 2 gives 0x1A5 next cycle.
- Twelve write frames, addr 0..11, data = addr+0x100, 4 idle cycles between frames → 12 wr_valid pulses; all_written rises with the 12th pulse; side reads all match.
- After the 0x1A5 write, read frame to addr 2 → sdo_oe high for slots 7..15; sdo = 1,1,0,1,0,0,1,0,1; rd_done pulses; no wr_valid.
- Write frame with ad_sload raised after 10 bits → frame_err pulse; register unchanged. Write to addr 13 → frame_err, no wr_valid. Frame held low for 20 bits → frame_err on release, no commit.
- Reset asserted at slot 8 of a write, then a clean write addr 5, data 0x0FF → no pulses from the aborted frame; regfile all 0 except addr 5 = 0x0FF; all_written = 0.
